// File: rtl/bsg_wormhole_packet_tx.sv
// Wormhole packet injector: takes one wide message per handshake and emits a header
// flit followed by back-to-back body flits toward a wormhole router input port.
module bsg_wormhole_packet_tx #(
   parameter int width_p             = 32,
   parameter int x_cord_width_p      = 4,
   parameter int y_cord_width_p      = 4,
   parameter int len_width_p         = 4,
   parameter int max_payload_flits_p = 4,
   parameter bit header_on_lsb_p     = 1'b1,
   localparam int hdr_data_width_lp  = width_p - x_cord_width_p - y_cord_width_p - len_width_p
) (
   input  logic                                   clk_i,
   input  logic                                   reset_n_i,
   input  logic                                   v_i,
   output logic                                   ready_o,
   input  logic [x_cord_width_p-1:0]              dest_x_i,
   input  logic [y_cord_width_p-1:0]              dest_y_i,
   input  logic [len_width_p-1:0]                 len_i,
   input  logic [hdr_data_width_lp-1:0]           hdr_data_i,
   input  logic [max_payload_flits_p*width_p-1:0] payload_i,
   output logic                                   v_o,
   output logic [width_p-1:0]                     data_o,
   input  logic                                   ready_i
);

   typedef enum logic [1:0] {IDLE, HDR, BODY} state_e;

   localparam logic [len_width_p-1:0] max_len_lp = len_width_p'(max_payload_flits_p);
   localparam logic [len_width_p-1:0] max_idx_lp = len_width_p'(max_payload_flits_p - 1);

   state_e                               state_r, state_n;
   logic [len_width_p-1:0]               cnt_r, len_r, body_idx;
   logic [x_cord_width_p-1:0]            x_r;
   logic [y_cord_width_p-1:0]            y_r;
   logic [hdr_data_width_lp-1:0]         hdr_data_r;
   logic [max_payload_flits_p*width_p-1:0] payload_r;
   logic [width_p-1:0]                   header, body_flit;
   logic                                 xfer, last_xfer, accept;

   assign v_o     = (state_r != IDLE);
   assign xfer    = v_o & ready_i;
   assign ready_o = (state_r == IDLE) | last_xfer;
   assign accept  = v_i & ready_o;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      last_xfer = 1'b0;
      if (xfer) begin
         if (state_r == HDR)  last_xfer = (len_r == '0);
         if (state_r == BODY) last_xfer = (cnt_r == len_r - len_width_p'(1));
      end
   end

   always_comb begin
      state_n = state_r;
      if (accept)                      state_n = HDR;
      else if (last_xfer)              state_n = IDLE;
      else if (xfer && state_r == HDR) state_n = BODY;
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!reset_n_i) begin
         state_r <= IDLE;
         cnt_r   <= '0;
         len_r   <= '0;
      end else begin
         state_r <= state_n;
         if (accept) begin
            cnt_r <= '0;
            len_r <= len_i;
         end else if (xfer && state_r == BODY) begin
            cnt_r <= cnt_r + len_width_p'(1);
         end
      end
   end

   // NOTE: the message datapath is deliberately left without reset; it is only read after a capture.
   always_ff @(posedge clk_i) begin
      if (accept) begin
         x_r        <= dest_x_i;
         y_r        <= dest_y_i;
         hdr_data_r <= hdr_data_i;
         payload_r  <= payload_i;
         assert (len_i <= max_len_lp)
            else $error("bsg_wormhole_packet_tx: len_i=%0d exceeds capacity %0d", len_i, max_payload_flits_p);
      end
   end

   always_comb begin
      if (header_on_lsb_p) header = {hdr_data_r, len_r, y_r, x_r};
      else                 header = {x_r, y_r, len_r, hdr_data_r};
   end

   // Illegal oversize lengths keep resending the final payload slot rather than indexing out of range.
   assign body_idx = (cnt_r > max_idx_lp) ? max_idx_lp : cnt_r;

   always_comb begin
      body_flit = '0;
      for (int k = 0; k < max_payload_flits_p; k++) begin
         if (body_idx == len_width_p'(k)) body_flit = payload_r[k*width_p +: width_p];
      end
   end

   always_comb begin
      unique case (state_r)
         HDR:     data_o = header;
         BODY:    data_o = body_flit;
         default: data_o = '0;
      endcase
   end

endmodule

// File: tb/tb_bsg_wormhole_packet_tx.sv
// Directed bench for bsg_wormhole_packet_tx: header layouts, stalls, back-to-back packets,
// maximum length and mid-packet reset, checked against hand-computed flits.
module tb_bsg_wormhole_packet_tx;

   logic         clk_i = 1'b0;
   logic         reset_n_i;
   logic         v_i, ready_i;
   logic [3:0]   dest_x_i, dest_y_i, len_i;
   logic [19:0]  hdr_data_i;
   logic [127:0] payload_i;
   logic         ready_o, v_o, ready_o_m, v_o_m;
   logic [31:0]  data_o, data_o_m;

   int n_asserts = 0;
   int n_fail    = 0;
   int out_cnt;

   always #5 clk_i = ~clk_i;

   bsg_wormhole_packet_tx #(.header_on_lsb_p(1'b1)) dut (
      .clk_i(clk_i), .reset_n_i(reset_n_i), .v_i(v_i), .ready_o(ready_o),
      .dest_x_i(dest_x_i), .dest_y_i(dest_y_i), .len_i(len_i), .hdr_data_i(hdr_data_i),
      .payload_i(payload_i), .v_o(v_o), .data_o(data_o), .ready_i(ready_i));

   bsg_wormhole_packet_tx #(.header_on_lsb_p(1'b0)) dut_msb (
      .clk_i(clk_i), .reset_n_i(reset_n_i), .v_i(v_i), .ready_o(ready_o_m),
      .dest_x_i(dest_x_i), .dest_y_i(dest_y_i), .len_i(len_i), .hdr_data_i(hdr_data_i),
      .payload_i(payload_i), .v_o(v_o_m), .data_o(data_o_m), .ready_i(ready_i));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp)
         else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
         end
   endtask

   task automatic step();
      @(posedge clk_i);
      #2;
   endtask

   task automatic put_msg(input logic [3:0] x, input logic [3:0] y, input logic [3:0] len,
                          input logic [19:0] hd, input logic [127:0] pl);
      dest_x_i   = x;
      dest_y_i   = y;
      len_i      = len;
      hdr_data_i = hd;
      payload_i  = pl;
   endtask

   // Holds ready_i low for `stalls` cycles, then transfers; data must not move during the stall.
   task automatic expect_flit(input string tag, input logic [31:0] exp, input int stalls, input bit is_last);
      for (int i = 0; i < stalls; i++) begin
         ready_i = 1'b0;
         #1;
         check({tag, "_stall_v"},   {31'b0, v_o},     32'd1);
         check({tag, "_stall_d"},   data_o,           exp);
         check({tag, "_stall_rdy"}, {31'b0, ready_o}, 32'd0);
         step();
      end
      ready_i = 1'b1;
      #1;
      check({tag, "_v"},   {31'b0, v_o},     32'd1);
      check({tag, "_d"},   data_o,           exp);
      check({tag, "_rdy"}, {31'b0, ready_o}, {31'b0, is_last});
      step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_n_i = 1'b0;
      v_i       = 1'b0;
      ready_i   = 1'b0;
      put_msg(4'h0, 4'h0, 4'h0, 20'h0, 128'h0);
      #3;
      check("rst_v",     {31'b0, v_o},     32'd0);
      check("rst_ready", {31'b0, ready_o}, 32'd1);
      check("rst_data",  data_o,           32'h0);
      step();
      reset_n_i = 1'b1;
      step();
      check("idle_v",     {31'b0, v_o},     32'd0);
      check("idle_ready", {31'b0, ready_o}, 32'd1);

      // Single-flit packet: ready_o rises in the same cycle as its only transfer.
      put_msg(4'd3, 4'd5, 4'd0, 20'hABCDE, 128'h0);
      v_i = 1'b1;
      step();
      v_i = 1'b0;
      ready_i = 1'b1;
      #1;
      check("single_msb_hdr", data_o_m, 32'h350ABCDE);
      expect_flit("single", 32'hABCDE053, 0, 1'b1);
      #1;
      check("single_done_v", {31'b0, v_o}, 32'd0);

      // Three body flits with ready_i pattern 1,0,0,1,1,0,1.
      put_msg(4'd1, 4'd2, 4'd3, 20'h12345, {32'h44, 32'h33, 32'h22, 32'h11});
      v_i = 1'b1;
      step();
      v_i = 1'b0;
      expect_flit("multi_hdr", 32'h12345321, 0, 1'b0);
      expect_flit("multi_b0",  32'h00000011, 2, 1'b0);
      expect_flit("multi_b1",  32'h00000022, 0, 1'b0);
      expect_flit("multi_b2",  32'h00000033, 1, 1'b1);
      #1;
      check("multi_done_v", {31'b0, v_o}, 32'd0);

      // Back-to-back: second header must follow the first packet's last flit directly.
      put_msg(4'd4, 4'd6, 4'd2, 20'h00001, {32'h0, 32'h0, 32'hA2, 32'hA1});
      v_i = 1'b1;
      step();
      put_msg(4'd7, 4'd8, 4'd1, 20'hFFFFF, {32'h0, 32'h0, 32'h0, 32'hB1});
      expect_flit("b2b_a_hdr", 32'h00001264, 0, 1'b0);
      expect_flit("b2b_a_b0",  32'h000000A1, 0, 1'b0);
      expect_flit("b2b_a_b1",  32'h000000A2, 0, 1'b1);
      expect_flit("b2b_b_hdr", 32'hFFFFF187, 0, 1'b0);
      v_i = 1'b0;
      expect_flit("b2b_b_b0",  32'h000000B1, 0, 1'b1);
      #1;
      check("b2b_done_v", {31'b0, v_o}, 32'd0);

      // MSB header mode alongside the LSB instance.
      put_msg(4'hF, 4'hA, 4'd0, 20'h55555, 128'h0);
      v_i = 1'b1;
      step();
      v_i = 1'b0;
      ready_i = 1'b1;
      #1;
      check("msb_x",    {28'b0, data_o_m[31:28]}, 32'hF);
      check("msb_y",    {28'b0, data_o_m[27:24]}, 32'hA);
      check("msb_len",  {28'b0, data_o_m[23:20]}, 32'h0);
      check("msb_full", data_o_m,                 32'hFA055555);
      check("msb_v",    {31'b0, v_o_m},           32'd1);
      expect_flit("msb_lsb_twin", 32'h555550AF, 0, 1'b1);

      // Maximum length, with a router-side remaining-flit counter.
      put_msg(4'd2, 4'd1, 4'd4, 20'h0000F, {32'hD4, 32'hD3, 32'hD2, 32'hD1});
      v_i = 1'b1;
      step();
      v_i = 1'b0;
      ready_i = 1'b1;
      #1;
      out_cnt = int'(data_o[11:8]);
      expect_flit("max_hdr", 32'h0000F412, 0, 1'b0);
      for (int k = 0; k < 4; k++) begin
         expect_flit($sformatf("max_b%0d", k), 32'hD1 + 32'(k), 0, k == 3);
         out_cnt--;
      end
      check("max_outcnt", 32'(out_cnt), 32'd0);
      #1;
      check("max_done_v", {31'b0, v_o}, 32'd0);

      // Reset in the middle of a body, then a fresh packet starts with its header.
      put_msg(4'd1, 4'd1, 4'd3, 20'h0000C, {32'h0, 32'hC3, 32'hC2, 32'hC1});
      v_i = 1'b1;
      step();
      v_i = 1'b0;
      expect_flit("rmid_hdr", 32'h0000C311, 0, 1'b0);
      expect_flit("rmid_b0",  32'h000000C1, 0, 1'b0);
      reset_n_i = 1'b0;
      #1;
      check("rmid_v",     {31'b0, v_o},     32'd0);
      check("rmid_ready", {31'b0, ready_o}, 32'd1);
      check("rmid_data",  data_o,           32'h0);
      #1;
      reset_n_i = 1'b1;
      step();
      put_msg(4'd9, 4'd9, 4'd0, 20'h00042, 128'h0);
      v_i = 1'b1;
      #1;
      check("rpost_ready", {31'b0, ready_o}, 32'd1);
      step();
      v_i = 1'b0;
      expect_flit("rpost_hdr", 32'h00042099, 0, 1'b1);
      #1;
      check("rpost_done_v", {31'b0, v_o}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
